// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the digit-serial BCD datapath.
package bcd_pkg;
  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_MAX     = 9;
  localparam int unsigned BCD_CORR    = 6;

  typedef enum logic [1:0] {IDLE, ADD, FIX} state_t;

  // Nine's complement of one digit; wraps mod 16 for non-decimal codes.
  function automatic logic [BCD_DIGIT_W-1:0] nines(input logic [BCD_DIGIT_W-1:0] d);
    return BCD_DIGIT_W'(BCD_MAX) - d;
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// Single corrected BCD digit adder: binary sum of x+y+cin, +6 when it reaches ten.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic                   cin,
  input  logic [BCD_DIGIT_W-1:0] x,
  input  logic [BCD_DIGIT_W-1:0] y,
  output logic                   cout,
  output logic [BCD_DIGIT_W-1:0] s
);
  localparam int unsigned Z_W = BCD_DIGIT_W + 1;

  logic [Z_W-1:0] z_c;
  logic [Z_W-1:0] zc_c;

  always_comb begin
    z_c  = Z_W'(x) + Z_W'(y) + Z_W'(cin);
    zc_c = (z_c < Z_W'(BCD_MAX + 1)) ? z_c : z_c + Z_W'(BCD_CORR);
  end

  assign {cout, s} = zc_c;
endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract, LSD first, one shared digit slice; subtraction
// results are returned as sign-magnitude via an in-place ten's-complement pass.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          sub,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          neg,
  output logic                          invalid
);
  localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, sub_q, sub_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, neg_q, neg_d, inv_q, inv_d;

  logic [BCD_DIGIT_W-1:0] x_c, y_c, s_c;
  logic                   co_c, last_c, inv_c;
  logic [W-1:0]           res_sh_c;

  // Slice operand muxes: ADD consumes a/b, FIX complements the stored result.
  always_comb begin
    x_c = a_q[BCD_DIGIT_W-1:0];
    y_c = sub_q ? nines(b_q[BCD_DIGIT_W-1:0]) : b_q[BCD_DIGIT_W-1:0];
    if (state_q == FIX) begin
      x_c = nines(res_q[BCD_DIGIT_W-1:0]);
      y_c = '0;
    end
  end

  bcd_digit_add u_slice (
    .cin  (carry_q),
    .x    (x_c),
    .y    (y_c),
    .cout (co_c),
    .s    (s_c)
  );

  assign last_c   = (cnt_q == CNT_W'(DIGITS - 1));
  assign res_sh_c = (res_q >> BCD_DIGIT_W) | (W'(s_c) << (W - BCD_DIGIT_W));

  always_comb begin
    inv_c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      inv_c = inv_c
            | (a[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX))
            | (b[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_c) state_d = (sub_q && !co_c) ? FIX : IDLE;
      FIX:     if (last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          inv_d   = inv_c;
          sum_d   = '0;
          cout_d  = 1'b0;
          neg_d   = 1'b0;
        end
      end
      ADD: begin
        a_d     = a_q >> BCD_DIGIT_W;
        b_d     = b_q >> BCD_DIGIT_W;
        res_d   = res_sh_c;
        carry_d = co_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          cnt_d = '0;
          if (sub_q && !co_c) begin
            // Borrow out: result is the complement of the magnitude.
            neg_d   = 1'b1;
            carry_d = 1'b1;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
            sum_d  = res_sh_c;
            cout_d = ~sub_q & co_c;
          end
        end
      end
      FIX: begin
        res_d   = res_sh_c;
        carry_d = co_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          cnt_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
          sum_d  = res_sh_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      inv_q   <= inv_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign neg     = neg_q;
  assign invalid = inv_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub: 4-digit and 1-digit instances, directed
// hazards plus random operands checked against a decimal reference model.
module tb_bcd_serial_addsub;
  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        neg;
    logic        inv;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, sub4, start1, sub1;
  logic [15:0] a4, b4, sum4;
  logic [3:0]  a1, b1, sum1;
  logic        busy4, done4, cout4, neg4, inv4;
  logic        busy1, done1, cout1, neg1, inv1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t q4[$];
  exp_t q1[$];
  exp_t last4;
  bit   have_last4 = 0;
  logic prev_done4 = 1'b0;
  logic prev_done1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_serial_addsub #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .neg(neg4), .invalid(inv4)
  );

  bcd_serial_addsub #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .neg(neg1), .invalid(inv1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v, input int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v, input int d);
    logic [15:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: decimal arithmetic for legal operands, digit rules for illegal ones.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic s, input int d);
    exp_t e;
    int   m = 1;
    int   ai, bi, c, z, x;
    int   r[4];
    e.sum = '0; e.cout = 1'b0; e.neg = 1'b0; e.inv = 1'b0; e.lat = d; e.acc = 0;
    for (int i = 0; i < d; i++) begin
      m = m * 10;
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) e.inv = 1'b1;
    end
    if (!e.inv) begin
      ai = bcd2int(av, d);
      bi = bcd2int(bv, d);
      if (!s) begin
        e.sum  = int2bcd((ai + bi) % m, d);
        e.cout = (ai + bi) >= m;
      end else if (ai >= bi) begin
        e.sum = int2bcd(ai - bi, d);
      end else begin
        e.sum = int2bcd(bi - ai, d);
        e.neg = 1'b1;
        e.lat = 2 * d;
      end
    end else begin
      c = int'(s);
      for (int i = 0; i < d; i++) begin
        x = s ? ((9 - int'(bv[4*i +: 4])) & 15) : int'(bv[4*i +: 4]);
        z = int'(av[4*i +: 4]) + x + c;
        if (z >= 10) z = (z + 6) % 32;
        r[i] = z % 16;
        c = z / 16;
      end
      if (!s) e.cout = c[0];
      else if (c == 0) begin
        e.neg = 1'b1;
        e.lat = 2 * d;
        c = 1;
        for (int i = 0; i < d; i++) begin
          z = ((9 - r[i]) & 15) + c;
          if (z >= 10) z = (z + 6) % 32;
          r[i] = z % 16;
          c = z / 16;
        end
      end
      for (int i = 0; i < d; i++) e.sum[4*i +: 4] = 4'(r[i]);
    end
    return e;
  endfunction

  // Monitor for the 4-digit instance: scoreboard on done, hold check while idle.
  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      check("done_width4", 32'(prev_done4), 0);
      check("busy_at_done4", 32'(busy4), 0);
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_done4: got done=1, expected no pending op (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        check("sum4", 32'(sum4), 32'(e.sum));
        check("cout4", 32'(cout4), 32'(e.cout));
        check("neg4", 32'(neg4), 32'(e.neg));
        check("invalid4", 32'(inv4), 32'(e.inv));
        check("latency4", cyc - e.acc, e.lat);
        last4 = e;
        have_last4 = 1;
      end
    end else if (!busy4 && have_last4) begin
      check("hold_sum4", 32'(sum4), 32'(last4.sum));
      check("hold_flags4", {29'd0, cout4, neg4, inv4}, {29'd0, last4.cout, last4.neg, last4.inv});
    end
    prev_done4 = done4;
  end

  // Monitor for the 1-digit instance.
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      check("done_width1", 32'(prev_done1), 0);
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_done1: got done=1, expected no pending op (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        check("sum1", 32'(sum1), 32'(e.sum));
        check("cout1", 32'(cout1), 32'(e.cout));
        check("neg1", 32'(neg1), 32'(e.neg));
        check("invalid1", 32'(inv1), 32'(e.inv));
        check("latency1", cyc - e.acc, e.lat);
      end
    end
    prev_done1 = done1;
  end

  // Drive one start pulse; entered and left at posedge+1.
  task automatic issue(input bit u1, input logic [15:0] av, input logic [15:0] bv, input logic s);
    exp_t e;
    e = model(av, bv, s, u1 ? 1 : 4);
    e.acc = cyc + 1;
    if (u1) begin
      start1 = 1'b1; a1 = av[3:0]; b1 = bv[3:0]; sub1 = s;
      q1.push_back(e);
    end else begin
      start4 = 1'b1; a4 = av; b4 = bv; sub4 = s;
      q4.push_back(e);
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Returns at posedge+1 of the done cycle; busy must stay high until then.
  task automatic wait_done(input bit u1);
    int n = 0;
    int bad = 0;
    while (!(u1 ? done1 : done4) && n < 40) begin
      if (!(u1 ? busy1 : busy4)) bad++;
      @(posedge clk); #1;
      n++;
    end
    check(u1 ? "done_seen1" : "done_seen4", 32'(u1 ? done1 : done4), 1);
    check(u1 ? "busy_held1" : "busy_held4", bad, 0);
  endtask

  task automatic run(input bit u1, input logic [15:0] av, input logic [15:0] bv, input logic s);
    issue(u1, av, bv, s);
    wait_done(u1);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rnd_bcd(input bit allow_inv);
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = (allow_inv && $urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                             : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy4), 0);
    check("rst_done", 32'(done4), 0);
    check("rst_sum", 32'(sum4), 0);
    check("rst_cout", 32'(cout4), 0);
    check("rst_neg", 32'(neg4), 0);
    check("rst_invalid", 32'(inv4), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 16'h1234, 16'h5678, 1'b0);
    run(0, 16'h9999, 16'h0001, 1'b0);
    run(0, 16'h5000, 16'h1234, 1'b1);
    run(0, 16'h1234, 16'h1234, 1'b1);
    run(0, 16'h1234, 16'h5000, 1'b1);
    run(0, 16'h00A0, 16'h0000, 1'b0);
    run(0, 16'h0042, 16'h0017, 1'b0);

    // start held high through the busy window: one operation only
    begin
      exp_t e;
      e = model(16'h0808, 16'h0303, 1'b1, 4);
      e.acc = cyc + 1;
      start4 = 1'b1; a4 = 16'h0808; b4 = 16'h0303; sub4 = 1'b1;
      q4.push_back(e);
      repeat (4) begin @(posedge clk); #1; end
      start4 = 1'b0;
      wait_done(0);
      repeat (6) begin @(posedge clk); #1; end
    end

    // reset two cycles into an operation: outputs clear, no done
    issue(0, 16'h4321, 16'h8765, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    q4.delete();
    have_last4 = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy4), 0);
    check("abort_done", 32'(done4), 0);
    check("abort_sum", 32'(sum4), 0);
    check("abort_flags", {29'd0, cout4, neg4, inv4}, 0);
    repeat (12) begin @(posedge clk); #1; end

    // back-to-back: new start presented in the done cycle
    issue(0, 16'h2500, 16'h7500, 1'b0);
    wait_done(0);
    issue(0, 16'h0001, 16'h0002, 1'b1);
    wait_done(0);
    issue(0, 16'h9000, 16'h0999, 1'b1);
    wait_done(0);
    @(posedge clk); #1;

    // single-digit instance
    run(1, 16'h0009, 16'h0009, 1'b0);
    run(1, 16'h0003, 16'h0007, 1'b1);
    issue(1, 16'h0007, 16'h0002, 1'b1);
    wait_done(1);
    issue(1, 16'h0005, 16'h0005, 1'b0);
    wait_done(1);
    @(posedge clk); #1;

    // random operands, sometimes back-to-back
    for (int i = 0; i < 60; i++) begin
      ra = rnd_bcd(1'b1);
      rb = rnd_bcd(1'b1);
      issue(0, ra, rb, 1'($urandom_range(0, 1)));
      wait_done(0);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      ra = rnd_bcd(1'b1);
      rb = rnd_bcd(1'b1);
      issue(1, ra, rb, 1'($urandom_range(0, 1)));
      wait_done(1);
    end

    repeat (5) begin @(posedge clk); #1; end
    check("pending4", q4.size(), 0);
    check("pending1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
